// File: rtl/vcxo_pkg.sv
// Shared types and constants for the VCXO discipline loop sequencer.
// Holds the FSM state set, step ladder thresholds/sizes and datapath widths.
package vcxo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    WAIT   = 3'd2,
    CALC   = 3'd3,
    ADJUST = 3'd4,
    CLAMP  = 3'd5
  } vcxo_state_e;

  localparam int MEAS_W = 32;
  localparam int CORR_W = 8;
  localparam int CALC_W = 34;
  localparam int ERR_W  = 32;
  localparam int PWM_W  = 16;
  localparam int SUM_W  = 18;
  localparam int STEP_W = 8;

  localparam int THR_FINE   = 1;
  localparam int THR_MID    = 10;
  localparam int THR_COARSE = 50;

  localparam int STEP_FINE   = 1;
  localparam int STEP_MID    = 20;
  localparam int STEP_COARSE = 100;

endpackage

// File: rtl/vcxo_step_calc.sv
// Combinational step ladder: maps a frequency error onto a signed duty step.
// in_band flags an error within the fine threshold (counts toward lock).
module vcxo_step_calc
  import vcxo_pkg::*;
(
  input  logic signed [ERR_W-1:0]  err,
  output logic signed [STEP_W-1:0] step,
  output logic                     in_band
);

  // Negative error means the VCXO runs slow, so the duty is pushed up.
  always_comb begin
    step = '0;
    if (err < -THR_COARSE)      step = STEP_W'(STEP_COARSE);
    else if (err < -THR_MID)    step = STEP_W'(STEP_MID);
    else if (err < -THR_FINE)   step = STEP_W'(STEP_FINE);
    else if (err > THR_COARSE)  step = STEP_W'(-STEP_COARSE);
    else if (err > THR_MID)     step = STEP_W'(-STEP_MID);
    else if (err > THR_FINE)    step = STEP_W'(-STEP_FINE);
  end

  assign in_band = (err >= -THR_FINE) && (err <= THR_FINE);

endmodule

// File: rtl/vcxo_loop_sequencer.sv
// VCXO discipline loop: requests gated counts, computes the frequency error,
// steps and clamps the PWM duty setpoint, and tracks lock / holdover status.
module vcxo_loop_sequencer
  import vcxo_pkg::*;
#(
  parameter int VCXO_NOMINAL   = 12288000,
  parameter int PWM_MAX        = 32000,
  parameter int PWM_INIT       = 16000,
  parameter int LOCK_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [CORR_W-1:0] VCXO_correction,
  output logic                     meas_start,
  input  logic                     meas_done,
  input  logic [MEAS_W-1:0]        meas_count,
  output logic signed [ERR_W-1:0]  freq_error,
  output logic signed [PWM_W-1:0]  PWM,
  output logic                     locked,
  output logic                     holdover
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic signed [CALC_W-1:0] ERR_HI =
    {{(CALC_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] ERR_LO = ~ERR_HI;

  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [CALC_W-1:0] x);
    if (x > ERR_HI)      return ERR_HI[ERR_W-1:0];
    else if (x < ERR_LO) return ERR_LO[ERR_W-1:0];
    else                 return x[ERR_W-1:0];
  endfunction

  function automatic logic signed [PWM_W-1:0] clamp_pwm(input logic signed [SUM_W-1:0] s);
    if (s < 0)                     return '0;
    else if (s > SUM_W'(PWM_MAX))  return PWM_W'(PWM_MAX);
    else                           return s[PWM_W-1:0];
  endfunction

  vcxo_state_e              state, state_nxt;
  logic                     meas_ok, timeout;
  logic [TO_W-1:0]          to_cnt;
  logic [LK_W-1:0]          streak;
  logic [MEAS_W-1:0]        count_p0;
  logic signed [SUM_W-1:0]  sum_p1;
  logic signed [CALC_W-1:0] diff_p0;
  logic signed [STEP_W-1:0] step;
  logic                     in_band, far_off;

  vcxo_step_calc u_step (
    .err     (freq_error),
    .step    (step),
    .in_band (in_band)
  );

  // A step of the mid size or larger means |e| exceeded the mid threshold.
  assign far_off = (step >= STEP_W'(STEP_MID)) || (step <= STEP_W'(-STEP_MID));

  assign diff_p0 = $signed({2'b00, count_p0}) - CALC_W'(VCXO_NOMINAL)
                 + CALC_W'(VCXO_correction);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    meas_ok   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:   if (enable) state_nxt = ARM;
      ARM:    state_nxt = enable ? WAIT : IDLE;
      WAIT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (meas_done) begin
          meas_ok   = 1'b1;
          state_nxt = CALC;
        end else if (to_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ARM;
        end
      end
      CALC:   state_nxt = enable ? ADJUST : IDLE;
      ADJUST: state_nxt = enable ? CLAMP  : IDLE;
      CLAMP:  state_nxt = enable ? ARM    : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: count capture; stage p1: stepped (unclamped) duty.
  always_ff @(posedge clk_in) begin
    if (meas_ok)                 count_p0 <= meas_count;
    if (state == ADJUST)         sum_p1   <= SUM_W'(PWM) + SUM_W'(step);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      meas_start <= 1'b0;
      freq_error <= '0;
      PWM        <= PWM_W'(PWM_INIT);
      locked     <= 1'b0;
      holdover   <= 1'b0;
      streak     <= '0;
      to_cnt     <= '0;
    end else begin
      meas_start <= (state == ARM) && enable;

      if (state == ARM)       to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + TO_W'(1);

      if (meas_ok) holdover <= 1'b0;
      if (timeout) begin
        holdover <= 1'b1;
        locked   <= 1'b0;
        streak   <= '0;
      end

      if (state == CALC && enable) freq_error <= sat_err(diff_p0);

      if (state == ADJUST && enable) begin
        if (in_band) begin
          if (streak < LK_W'(LOCK_COUNT))     streak <= streak + LK_W'(1);
          if (streak >= LK_W'(LOCK_COUNT - 1)) locked <= 1'b1;
        end else begin
          streak <= '0;
          if (far_off) locked <= 1'b0;
        end
      end

      if (state == CLAMP) PWM <= clamp_pwm(sum_p1);

      // Parking the loop drops lock; holdover reflects the last measurement.
      if (!enable && state != IDLE) begin
        locked <= 1'b0;
        streak <= '0;
      end
    end
  end

endmodule

// File: doc/vcxo_loop_sequencer.md
VCXO_LOOP_SEQUENCER -- requirements
Module: vcxo_loop_sequencer

Interface
REQ-001 Parameter VCXO_NOMINAL, default 12288000: expected VCXO count per gate (x10 Hz).
REQ-002 Parameter PWM_MAX, default 32000: upper duty limit.
REQ-003 Parameter PWM_INIT, default 16000: duty after reset.
REQ-004 Parameter LOCK_COUNT, default 8: consecutive in-band measurements needed to declare lock.
REQ-005 Parameter TIMEOUT_CYCLES, default 2000000: clk_in cycles to wait for meas_done.
REQ-006 clk_in  input  1  single clock; all logic on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high = loop runs; low = loop parked.
REQ-009 VCXO_correction  input  8 signed  user offset added to error.
REQ-010 meas_start  output  1  one-cycle pulse requesting one gated count.
REQ-011 meas_done  input  1  one-cycle pulse; meas_count valid same cycle.
REQ-012 meas_count  input  32 unsigned  VCXO edges counted in gate.
REQ-013 freq_error  output  32 signed  last computed error.
REQ-014 PWM  output  16 signed  duty setpoint to PWM generator.
REQ-015 locked  output  1  loop locked.
REQ-016 holdover  output  1  last measurement timed out; PWM frozen.

Function
REQ-017 FSM states SHALL be IDLE, ARM, WAIT, CALC, ADJUST, CLAMP.
REQ-018 IDLE: enable high -> ARM next cycle; else stay.
REQ-019 ARM: assert meas_start for exactly one cycle, clear timeout counter, -> WAIT.
REQ-020 WAIT: meas_done -> capture meas_count, clear holdover, -> CALC; timeout counter reaching TIMEOUT_CYCLES-1 without meas_done -> set holdover, clear locked and lock streak, -> ARM.
REQ-021 meas_done and timeout in same cycle: meas_done wins.
REQ-022 meas_done outside WAIT SHALL be ignored.
REQ-023 CALC: freq_error = meas_count - VCXO_NOMINAL + sign-extended VCXO_correction, computed 34-bit signed, saturated to 32-bit signed; -> ADJUST.
REQ-024 ADJUST step on e=freq_error: e<-50 +100; e<-10 +20; e<-1 +1; e>50 -100; e>10 -20; e>1 -1; else 0; sum held 18-bit signed; -> CLAMP.
REQ-025 CLAMP: PWM = sum clamped to [0, PWM_MAX]; -> ARM (enable high) or IDLE (enable low).
REQ-026 PWM SHALL change only on the CLAMP cycle; total measure-to-PWM latency 3 cycles after meas_done.
REQ-027 Lock streak counter: |e|<=1 increments (saturates at LOCK_COUNT), else clears; updated in ADJUST.
REQ-028 locked set when streak reaches LOCK_COUNT; cleared when |e|>10, on timeout, or on enable low.
REQ-029 enable low in ARM/WAIT/CALC/ADJUST -> IDLE next cycle, PWM held, pending measurement discarded, locked and streak cleared; holdover held.

Reset
REQ-030 reset_n low SHALL asynchronously force: state IDLE, meas_start 0, freq_error 0, PWM PWM_INIT, locked 0, holdover 0, streak 0, timeout counter 0.
REQ-031 First meas_start after reset release SHALL occur 2 cycles after enable is sampled high.

Structure
REQ-032 Shared package vcxo_pkg SHALL hold FSM state enum, step thresholds (1, 10, 50), step sizes (1, 20, 100), and error/PWM width constants.
REQ-033 Sub-module vcxo_step_calc SHALL be combinational: error in -> signed step out plus in-band flag.
REQ-034 Gate counter and PWM generator are external; this block only sequences them.

Verification
REQ-035 Reset, enable=1, meas_count=12288000, correction=0 -> freq_error 0, PWM stays 16000, locked after 8th measurement.
REQ-036 meas_count=12287900 -> freq_error -100, PWM 16100 three cycles after meas_done; 12288015 next -> freq_error +15, PWM 16080.
REQ-037 PWM=31950 and error -100 -> PWM clamps to 32000; PWM=50 and error +60 -> PWM 0.
REQ-038 No meas_done for TIMEOUT_CYCLES -> holdover 1, locked 0, PWM unchanged, new meas_start pulse; next meas_done clears holdover.
REQ-039 correction=-5, meas_count=12288003 -> freq_error -2, PWM +1; enable dropped in WAIT then meas_done -> ignored, PWM unchanged, state IDLE.
REQ-040 reset_n asserted mid-WAIT -> all outputs at reset values immediately, without a clock edge.
